// File: rtl/inner_inner_delay_unit_pkg.sv
// Shared defaults and the per-stage register layout for the dual-channel delay unit.
package inner_inner_delay_unit_pkg;

   localparam int unsigned DATA_WIDTH  = 5;
   localparam int unsigned DELAY_DEPTH = 3;

   typedef struct packed {
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
   } stage_t;

endpackage

// File: rtl/inner_inner_delay_unit_delay_channel.sv
// Single-channel elastic pipeline: DEPTH valid/data stages with bubble collapsing.
module delay_channel
   import inner_inner_delay_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH,
   parameter int unsigned DEPTH = DELAY_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   // Same layout as stage_t, sized by this instance's WIDTH.
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] data;
   } chan_stage_t;

   chan_stage_t      stg [DEPTH];
   logic [DEPTH-1:0] acc;

   // Accept ripples from the output back to stage 0 through a running term,
   // so acc is only ever written here and never read back within the loop.
   always_comb begin
      logic ahead;
      acc   = '0;
      ahead = out_ready;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         ahead            = ~stg[DEPTH-1-i].valid | ahead;
         acc[DEPTH-1-i]   = ahead;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stg[i] <= '0;
         end
      end else begin
         if (acc[0]) begin
            stg[0] <= '{valid: in_valid, data: in_data};
         end
         for (int unsigned i = 1; i < DEPTH; i++) begin
            if (acc[i]) begin
               stg[i] <= stg[i-1];
            end
         end
      end
   end

   assign in_ready  = acc[0];
   assign out_valid = stg[DEPTH-1].valid;
   assign out_data  = stg[DEPTH-1].data;

endmodule

// File: rtl/inner_inner_delay_unit.sv
// Two independent elastic delay channels sharing only clock and reset.
module inner_inner_delay_unit
   import inner_inner_delay_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_WIDTH,
   parameter int unsigned DEPTH = DELAY_DEPTH
) (
   input  logic             CLK,
   input  logic             ASYNCRESETN,
   input  logic [WIDTH-1:0] INPUT_0_data,
   input  logic             INPUT_0_valid,
   output logic             INPUT_0_ready,
   input  logic [WIDTH-1:0] INPUT_1_data,
   input  logic             INPUT_1_valid,
   output logic             INPUT_1_ready,
   output logic [WIDTH-1:0] OUTPUT_0_data,
   output logic             OUTPUT_0_valid,
   input  logic             OUTPUT_0_ready,
   output logic [WIDTH-1:0] OUTPUT_1_data,
   output logic             OUTPUT_1_valid,
   input  logic             OUTPUT_1_ready
);

   delay_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_chan0 (
      .clk       (CLK),
      .rst_n     (ASYNCRESETN),
      .in_data   (INPUT_0_data),
      .in_valid  (INPUT_0_valid),
      .in_ready  (INPUT_0_ready),
      .out_data  (OUTPUT_0_data),
      .out_valid (OUTPUT_0_valid),
      .out_ready (OUTPUT_0_ready)
   );

   delay_channel #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_chan1 (
      .clk       (CLK),
      .rst_n     (ASYNCRESETN),
      .in_data   (INPUT_1_data),
      .in_valid  (INPUT_1_valid),
      .in_ready  (INPUT_1_ready),
      .out_data  (OUTPUT_1_data),
      .out_valid (OUTPUT_1_valid),
      .out_ready (OUTPUT_1_ready)
   );

endmodule

// File: tb/tb_inner_inner_delay_unit.sv
// Directed self-checking bench for the dual-channel delay unit (WIDTH=5, DEPTH=3).
module tb_inner_inner_delay_unit;

   logic       clk;
   logic       rst_n;
   logic [4:0] in0_d, in1_d, out0_d, out1_d;
   logic       in0_v, in1_v, in0_r, in1_r;
   logic       out0_v, out1_v, out0_r, out1_r;

   int unsigned passed;
   int unsigned total;

   inner_inner_delay_unit #(
      .WIDTH (5),
      .DEPTH (3)
   ) dut (
      .CLK            (clk),
      .ASYNCRESETN    (rst_n),
      .INPUT_0_data   (in0_d),
      .INPUT_0_valid  (in0_v),
      .INPUT_0_ready  (in0_r),
      .INPUT_1_data   (in1_d),
      .INPUT_1_valid  (in1_v),
      .INPUT_1_ready  (in1_r),
      .OUTPUT_0_data  (out0_d),
      .OUTPUT_0_valid (out0_v),
      .OUTPUT_0_ready (out0_r),
      .OUTPUT_1_data  (out1_d),
      .OUTPUT_1_valid (out1_v),
      .OUTPUT_1_ready (out1_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chkd(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      in0_v  = 1'b0; in0_d = '0; out0_r = 1'b1;
      in1_v  = 1'b0; in1_d = '0; out1_r = 1'b1;

      // reset state, asynchronous: checked before any clock edge
      #1;
      chk1("rst_out0_valid", out0_v, 1'b0);
      chkd("rst_out0_data", out0_d, 5'h00);
      chk1("rst_out1_valid", out1_v, 1'b0);
      chkd("rst_out1_data", out1_d, 5'h00);
      out0_r = 1'b0; out1_r = 1'b0;
      #1;
      chk1("rst_in0_ready", in0_r, 1'b1);
      chk1("rst_in1_ready", in1_r, 1'b1);
      out0_r = 1'b1; out1_r = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;

      // single word, 3-cycle latency, channel 1 untouched
      in0_v = 1'b1; in0_d = 5'h15;
      for (int k = 1; k <= 3; k++) begin
         tick();
         in0_v = 1'b0;
         chk1("single_out0_valid", out0_v, (k == 3));
         chk1("single_out1_idle", out1_v, 1'b0);
      end
      chkd("single_out0_data", out0_d, 5'h15);
      tick();
      chk1("single_popped", out0_v, 1'b0);
      chk1("single_out1_idle_end", out1_v, 1'b0);

      // streaming 0..9 on both channels
      in0_v = 1'b1; in0_d = 5'd0;
      in1_v = 1'b1; in1_d = 5'd0;
      for (int c = 0; c <= 12; c++) begin
         tick();
         if (c + 1 < 10) begin
            in0_d = 5'(c + 1);
            in1_d = 5'(c + 1);
         end else begin
            in0_v = 1'b0;
            in1_v = 1'b0;
         end
         chk1("stream_out0_valid", out0_v, (c >= 2 && c <= 11));
         chk1("stream_out1_valid", out1_v, (c >= 2 && c <= 11));
         chk1("stream_in0_ready", in0_r, 1'b1);
         if (c >= 2 && c <= 11) begin
            chkd("stream_out0_data", out0_d, 5'(c - 2));
            chkd("stream_out1_data", out1_d, 5'(c - 2));
         end
      end

      // backpressure on channel 1
      out1_r = 1'b0;
      in1_v  = 1'b1; in1_d = 5'h01;
      tick();
      chk1("bp_ready_after1", in1_r, 1'b1);
      in1_d = 5'h02;
      tick();
      chk1("bp_ready_after2", in1_r, 1'b1);
      in1_d = 5'h03;
      tick();
      chk1("bp_ready_after3", in1_r, 1'b0);
      chk1("bp_out1_valid", out1_v, 1'b1);
      chkd("bp_out1_data", out1_d, 5'h01);
      in1_d = 5'h04;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk1("bp_stall_ready", in1_r, 1'b0);
         chk1("bp_stall_valid", out1_v, 1'b1);
         chkd("bp_stall_data", out1_d, 5'h01);
         chk1("bp_out0_idle", out0_v, 1'b0);
      end
      out1_r = 1'b1;
      #1;
      chk1("bp_release_ready", in1_r, 1'b1);
      tick();
      in1_v = 1'b0;
      chkd("bp_drain_2", out1_d, 5'h02);
      tick();
      chkd("bp_drain_3", out1_d, 5'h03);
      tick();
      chk1("bp_drain_4_valid", out1_v, 1'b1);
      chkd("bp_drain_4", out1_d, 5'h04);
      tick();
      chk1("bp_empty", out1_v, 1'b0);

      // full pipe with simultaneous push and pop on channel 0
      out0_r = 1'b0;
      in0_v  = 1'b1; in0_d = 5'h11;
      tick(); in0_d = 5'h12;
      tick(); in0_d = 5'h13;
      tick();
      chk1("full_ready_low", in0_r, 1'b0);
      in0_d  = 5'h14;
      out0_r = 1'b1;
      #1;
      chk1("full_pushpop_ready", in0_r, 1'b1);
      tick();
      in0_v  = 1'b0;
      out0_r = 1'b0;
      #1;
      chk1("full_still_full", in0_r, 1'b0);
      chkd("full_head_12", out0_d, 5'h12);
      out0_r = 1'b1;
      tick();
      chkd("full_drain_13", out0_d, 5'h13);
      tick();
      chkd("full_drain_14", out0_d, 5'h14);
      tick();
      chk1("full_empty", out0_v, 1'b0);

      // mid-flight asynchronous reset
      in0_v = 1'b1; in0_d = 5'h1A;
      in1_v = 1'b1; in1_d = 5'h1C;
      tick(); in0_d = 5'h1B; in1_d = 5'h1D;
      tick(); in0_v = 1'b0; in1_v = 1'b0;
      tick();
      chk1("mid_pre_out0_valid", out0_v, 1'b1);
      chkd("mid_pre_out0_data", out0_d, 5'h1A);
      #2;
      rst_n  = 1'b0;
      out0_r = 1'b0;
      #1;
      chk1("mid_rst_out0_valid", out0_v, 1'b0);
      chk1("mid_rst_out1_valid", out1_v, 1'b0);
      chkd("mid_rst_out0_data", out0_d, 5'h00);
      chk1("mid_rst_in0_ready", in0_r, 1'b1);
      tick();
      rst_n  = 1'b1;
      out0_r = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk1("mid_no_stale0", out0_v, 1'b0);
         chk1("mid_no_stale1", out1_v, 1'b0);
      end

      // channel 0 stalled full while channel 1 streams 0x0A..0x0F
      out0_r = 1'b0;
      in0_v  = 1'b1; in0_d = 5'h01;
      in1_v  = 1'b1; in1_d = 5'h0A;
      for (int c = 0; c <= 8; c++) begin
         tick();
         in0_d = (c < 2) ? 5'(c + 2) : 5'h04;
         if (c + 1 < 6) in1_d = 5'(10 + c + 1);
         else in1_v = 1'b0;
         chk1("ind_out1_valid", out1_v, (c >= 2 && c <= 7));
         if (c >= 2 && c <= 7) chkd("ind_out1_data", out1_d, 5'(10 + c - 2));
         if (c >= 2) begin
            chk1("ind_in0_ready", in0_r, 1'b0);
            chk1("ind_out0_valid", out0_v, 1'b1);
            chkd("ind_out0_data", out0_d, 5'h01);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/inner_inner_delay_unit.md
INNER_INNER_DELAY_UNIT -- requirements
Module: inner_inner_delay_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, giving the payload bits per channel.
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the pipeline stages per channel (the latency in cycles).
REQ-003 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 ASYNCRESETN  input  1  reset, asynchronous and active-low.
REQ-005 INPUT_0_data  input  WIDTH  channel-0 payload.
REQ-006 INPUT_0_valid  input  1  channel-0 payload present.
REQ-007 INPUT_0_ready  output  1  channel 0 can accept this cycle.
REQ-008 INPUT_1_data  input  WIDTH  channel-1 payload.
REQ-009 INPUT_1_valid  input  1  channel-1 payload present.
REQ-010 INPUT_1_ready  output  1  channel 1 can accept this cycle.
REQ-011 OUTPUT_0_data  output  WIDTH  delayed channel-0 payload.
REQ-012 OUTPUT_0_valid  output  1  OUTPUT_0_data is valid.
REQ-013 OUTPUT_0_ready  input  1  downstream accepts channel 0.
REQ-014 OUTPUT_1_data, OUTPUT_1_valid, OUTPUT_1_ready SHALL mirror REQ-011 to REQ-013 for channel 1.

Function
REQ-015 Channel k SHALL carry INPUT_k to OUTPUT_k only; the two channels SHALL be fully independent, with no shared state or cross-coupling.
REQ-016 A transfer SHALL occur on a port in any cycle where valid and ready are both 1 at the rising edge of CLK.
REQ-017 Each channel SHALL be a DEPTH-stage elastic pipeline; each stage SHALL hold one valid bit and one WIDTH-bit data register.
REQ-018 A stage SHALL be able to accept when its valid bit is 0 or the next stage can accept; the last stage uses OUTPUT_k_ready as "next can accept".
REQ-019 INPUT_k_ready SHALL equal the stage-0 accept signal, which is combinational from OUTPUT_k_ready.
REQ-020 When the stage ahead can accept, a stage SHALL load the previous stage's valid and data; otherwise it SHALL hold.
REQ-021 OUTPUT_k_valid and OUTPUT_k_data SHALL come directly from the last-stage registers, with no combinational input-to-output data path.
REQ-022 Latency: a word accepted at edge t with no backpressure SHALL present OUTPUT_k_valid=1 in the cycle after edge t+DEPTH-1, i.e. DEPTH cycles after INPUT_k_valid was sampled.
REQ-023 Throughput SHALL be one word per cycle per channel under continuous valid and ready.
REQ-024 Ordering SHALL be strict FIFO, with no loss or duplication.
REQ-025 While OUTPUT_k_valid=1 and OUTPUT_k_ready=0, OUTPUT_k_data SHALL stay stable and OUTPUT_k_valid SHALL stay 1.
REQ-026 Full condition: when all DEPTH stages are valid and OUTPUT_k_ready=0, INPUT_k_ready SHALL be 0.
REQ-027 Full with OUTPUT_k_ready=1: INPUT_k_ready SHALL be 1, so a simultaneous push and pop is accepted.
REQ-028 Empty condition: INPUT_k_ready SHALL be 1 regardless of OUTPUT_k_ready.
REQ-029 Data SHALL pass unmodified; no arithmetic is performed.
REQ-030 Bubbles, i.e. invalid stages, SHALL compress out when the stage ahead can accept.

Reset
REQ-031 While ASYNCRESETN=0, every stage valid bit SHALL clear immediately without waiting for CLK, and data registers SHALL clear to 0.
REQ-032 During reset, OUTPUT_k_valid=0, OUTPUT_k_data=0 and INPUT_k_ready=1.
REQ-033 Reset asserted mid-operation SHALL discard all in-flight words.
REQ-034 Deassertion of ASYNCRESETN SHALL be synchronised externally; the first transfer SHALL be possible at the first rising edge of CLK after deassertion.

Structure
REQ-035 A shared package inner_inner_delay_unit_pkg SHALL hold the defaults DATA_WIDTH=5 and DELAY_DEPTH=3, plus a packed struct typedef {valid, data} for a stage.
REQ-036 One sub-module, delay_channel, SHALL implement the single-channel DEPTH-stage elastic pipeline; the top SHALL instantiate it twice, once for channel 0 and once for channel 1.

Verification
REQ-037 Reset, then INPUT_0 single word 0x15 with OUTPUT_0_ready=1 held -> OUTPUT_0_valid rises 3 cycles later with data 0x15; OUTPUT_1_valid stays 0 throughout.
REQ-038 Streaming, valid held 10 cycles carrying 0..9 on both channels with ready=1 -> outputs 0..9 in order, back-to-back, starting at a 3-cycle offset.
REQ-039 Backpressure, OUTPUT_1_ready=0 while pushing 0x01, 0x02, 0x03, 0x04 -> INPUT_1_ready drops after 3 accepts, and 0x04 is held at the input; then OUTPUT_1_ready=1 -> 0x01..0x04 delivered in order, stable while stalled.
REQ-040 Full with simultaneous push/pop, pipe full and OUTPUT_0_ready=1, INPUT_0_valid=1 -> INPUT_0_ready=1 and occupancy stays 3.
REQ-041 Mid-flight reset, 2 words in flight then ASYNCRESETN=0 between edges -> OUTPUT valids drop to 0 immediately and no stale word appears after release.
REQ-042 Channel independence, channel 0 stalled full while channel 1 streams 0x0A..0x0F -> channel 1 is delivered with 3-cycle latency, unaffected by channel 0.
